mem_wb_stage: RTL and testbench

- Memory-access stage sitting directly downstream of the EX/MEM pipeline register.
- Consumes its registered outputs: PC+offset sum, ALU result, store data, control bits, Zero and Rd.
- Resolves branches, performs the data-memory access over a req/ack handshake (stalling the pipeline while it is outstanding), and owns the MEM/WB pipeline register that feeds writeback and forwarding.

---
 rtl/mem_wb_stage_pkg.sv | 21 ++
 rtl/mem_access_fsm.sv | 91 +++++++++
 rtl/mem_wb_stage.sv | 103 ++++++++++
 tb/tb_mem_wb_stage.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_stage_pkg.sv
// Shared types and constants for the memory-access / MEM-WB stage.
package mem_wb_stage_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned RD_W = 5;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_e;

    // Writeback control carried by the MEM/WB register.
    typedef struct packed {
        logic            mem_to_reg;
        logic            reg_write;
        logic [RD_W-1:0] rd;
    } wb_ctrl_t;

    localparam wb_ctrl_t WB_BUBBLE = '{mem_to_reg: 1'b0, reg_write: 1'b0, rd: '0};

endpackage

// File: rtl/mem_access_fsm.sv
// Data-memory request sequencer: issue, wait for ack, abort on timeout.
module mem_access_fsm
    import mem_wb_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mem_read_i,
    input  logic            mem_write_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic            mem_ack_i,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    output logic            misalign_err_o,
    output logic            timeout_err_o,
    output logic            stall_c,
    output logic            busy_c,
    output logic            done_c
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               memop;
    logic               aligned;
    logic               expire;

    assign memop   = mem_read_i | mem_write_i;
    assign aligned = (addr_i[2:0] == 3'b000);
    assign busy_c  = (state_q == S_ACCESS);
    assign done_c  = busy_c & mem_ack_i;
    assign expire  = busy_c & ~mem_ack_i & (cnt_q == CNT_W'(TIMEOUT - 1));
    assign cnt_d   = cnt_q + CNT_W'(1);

    // Hold upstream while an aligned access is being issued or is outstanding;
    // release in the ack cycle and in the cycle the access is abandoned.
    assign stall_c = (~busy_c & memop & aligned) | (busy_c & ~mem_ack_i & ~expire);

    // State, timeout counter, request registers and error pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            mem_req_o      <= 1'b0;
            mem_we_o       <= 1'b0;
            mem_addr_o     <= '0;
            mem_wdata_o    <= '0;
            misalign_err_o <= 1'b0;
            timeout_err_o  <= 1'b0;
        end else begin
            misalign_err_o <= 1'b0;
            timeout_err_o  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (memop) begin
                        if (aligned) begin
                            state_q     <= S_ACCESS;
                            cnt_q       <= '0;
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= mem_write_i;
                            mem_addr_o  <= addr_i;
                            mem_wdata_o <= wdata_i;
                        end else begin
                            misalign_err_o <= 1'b1;
                        end
                    end
                end
                S_ACCESS: begin
                    if (mem_ack_i) begin
                        state_q   <= S_IDLE;
                        mem_req_o <= 1'b0;
                    end else if (expire) begin
                        state_q       <= S_IDLE;
                        mem_req_o     <= 1'b0;
                        timeout_err_o <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage: branch resolution, data-memory access and the MEM/WB register.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] PCSum,
    input  logic [XLEN-1:0] ALUResult,
    input  logic [XLEN-1:0] StoreData,
    input  logic            Branch,
    input  logic            MemRead,
    input  logic            MemtoReg,
    input  logic            MemWrite,
    input  logic            RegWrite,
    input  logic            Zero,
    input  logic [RD_W-1:0] Rd,
    output logic            PCSrc,
    output logic [XLEN-1:0] BranchTarget,
    output logic            stall,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] ReadData_wb,
    output logic [XLEN-1:0] ALUResult_wb,
    output logic            MemtoReg_wb,
    output logic            RegWrite_wb,
    output logic [RD_W-1:0] Rd_wb,
    output logic            misalign_err,
    output logic            timeout_err
);

    logic            memop;
    logic            busy_c;
    logic            done_c;
    wb_ctrl_t        ctrl_in;
    wb_ctrl_t        wb_ctrl_q;
    logic [XLEN-1:0] read_wb_q;
    logic [XLEN-1:0] alu_wb_q;

    assign memop   = MemRead | MemWrite;
    assign ctrl_in = '{mem_to_reg: MemtoReg, reg_write: RegWrite, rd: Rd};

    // Branches are never memops, so the redirect is not gated by stall.
    assign PCSrc        = Branch & Zero;
    assign BranchTarget = PCSum;

    mem_access_fsm #(
        .TIMEOUT (TIMEOUT)
    ) u_fsm (
        .clk            (clk),
        .reset          (reset),
        .mem_read_i     (MemRead),
        .mem_write_i    (MemWrite),
        .addr_i         (ALUResult),
        .wdata_i        (StoreData),
        .mem_ack_i      (mem_ack),
        .mem_req_o      (mem_req),
        .mem_we_o       (mem_we),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .misalign_err_o (misalign_err),
        .timeout_err_o  (timeout_err),
        .stall_c        (stall),
        .busy_c         (busy_c),
        .done_c         (done_c)
    );

    // MEM/WB register: pass non-memory ops, retire completed accesses, else bubble.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wb_ctrl_q <= WB_BUBBLE;
            read_wb_q <= '0;
            alu_wb_q  <= '0;
        end else if (!busy_c) begin
            if (memop) begin
                wb_ctrl_q <= WB_BUBBLE;
            end else begin
                wb_ctrl_q <= ctrl_in;
                alu_wb_q  <= ALUResult;
            end
        end else if (done_c) begin
            wb_ctrl_q <= ctrl_in;
            alu_wb_q  <= ALUResult;
            if (!mem_we) begin
                read_wb_q <= mem_rdata;
            end
        end else begin
            wb_ctrl_q <= WB_BUBBLE;
        end
    end

    assign ReadData_wb  = read_wb_q;
    assign ALUResult_wb = alu_wb_q;
    assign MemtoReg_wb  = wb_ctrl_q.mem_to_reg;
    assign RegWrite_wb  = wb_ctrl_q.reg_write;
    assign Rd_wb        = wb_ctrl_q.rd;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage.
module tb_mem_wb_stage;

    localparam int unsigned XLEN    = 64;
    localparam int unsigned RD_W    = 5;
    localparam int unsigned TIMEOUT = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [XLEN-1:0] PCSum, ALUResult, StoreData;
    logic            Branch, MemRead, MemtoReg, MemWrite, RegWrite, Zero;
    logic [RD_W-1:0] Rd;
    logic            PCSrc;
    logic [XLEN-1:0] BranchTarget;
    logic            stall, mem_req, mem_we;
    logic [XLEN-1:0] mem_addr, mem_wdata;
    logic            mem_ack;
    logic [XLEN-1:0] mem_rdata;
    logic [XLEN-1:0] ReadData_wb, ALUResult_wb;
    logic            MemtoReg_wb, RegWrite_wb;
    logic [RD_W-1:0] Rd_wb;
    logic            misalign_err, timeout_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .PCSum(PCSum), .ALUResult(ALUResult), .StoreData(StoreData),
        .Branch(Branch), .MemRead(MemRead), .MemtoReg(MemtoReg), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .Zero(Zero), .Rd(Rd), .PCSrc(PCSrc), .BranchTarget(BranchTarget),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ReadData_wb(ReadData_wb), .ALUResult_wb(ALUResult_wb), .MemtoReg_wb(MemtoReg_wb),
        .RegWrite_wb(RegWrite_wb), .Rd_wb(Rd_wb), .misalign_err(misalign_err),
        .timeout_err(timeout_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        PCSum = '0; ALUResult = '0; StoreData = '0;
        Branch = 0; MemRead = 0; MemtoReg = 0; MemWrite = 0; RegWrite = 0; Zero = 0;
        Rd = '0; mem_ack = 0; mem_rdata = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_inputs();
        step();
        step();
        checks++;
        if ({mem_req, mem_we, misalign_err, timeout_err, MemtoReg_wb, RegWrite_wb} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 000000",
                {mem_req, mem_we, misalign_err, timeout_err, MemtoReg_wb, RegWrite_wb});
        end
        checks++;
        if ((mem_addr | mem_wdata | ReadData_wb | ALUResult_wb) !== '0 || Rd_wb !== '0) begin
            errors++; $display("FAIL reset_data: addr %h wdata %h rd %h alu %h rdwb %h expected 0",
                mem_addr, mem_wdata, ReadData_wb, ALUResult_wb, Rd_wb);
        end
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_alu_op();
        RegWrite = 1; Rd = 5'd7; ALUResult = 64'h2A;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL alu_stall: got %b expected 0", stall); end
        step();
        checks++;
        if (RegWrite_wb !== 1'b1 || Rd_wb !== 5'd7 || ALUResult_wb !== 64'h2A) begin
            errors++; $display("FAIL alu_wb: regwrite %b rd %0d alu %h expected 1 7 2a",
                RegWrite_wb, Rd_wb, ALUResult_wb);
        end
        checks++;
        if (stall !== 1'b0 || mem_req !== 1'b0) begin
            errors++; $display("FAIL alu_nostall: stall %b req %b expected 0 0", stall, mem_req);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_load();
        ALUResult = 64'h100; MemRead = 1; MemtoReg = 1; RegWrite = 1; Rd = 5'd3;
        #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL load_issue_stall: got %b expected 1", stall); end
        step();
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 64'h100) begin
            errors++; $display("FAIL load_req: req %b we %b addr %h expected 1 0 100", mem_req, mem_we, mem_addr);
        end
        checks++;
        if (stall !== 1'b1 || RegWrite_wb !== 1'b0 || Rd_wb !== 5'd0) begin
            errors++; $display("FAIL load_wait: stall %b regwrite_wb %b rd_wb %0d expected 1 0 0",
                stall, RegWrite_wb, Rd_wb);
        end
        step();
        checks++;
        if (RegWrite_wb !== 1'b0 || mem_req !== 1'b1) begin
            errors++; $display("FAIL load_bubble: regwrite_wb %b req %b expected 0 1", RegWrite_wb, mem_req);
        end
        mem_ack = 1; mem_rdata = 64'hDEADBEEF;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL load_ack_stall: got %b expected 0", stall); end
        step();
        clear_inputs();
        checks++;
        if (ReadData_wb !== 64'hDEADBEEF || MemtoReg_wb !== 1'b1 || RegWrite_wb !== 1'b1 || Rd_wb !== 5'd3) begin
            errors++; $display("FAIL load_wb: rdata %h memtoreg %b regwrite %b rd %0d expected deadbeef 1 1 3",
                ReadData_wb, MemtoReg_wb, RegWrite_wb, Rd_wb);
        end
        checks++;
        if (mem_req !== 1'b0 || ALUResult_wb !== 64'h100) begin
            errors++; $display("FAIL load_done: req %b alu_wb %h expected 0 100", mem_req, ALUResult_wb);
        end
        step();
    endtask

    task automatic test_store();
        ALUResult = 64'h108; StoreData = 64'h55; MemWrite = 1;
        #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL store_issue_stall: got %b expected 1", stall); end
        step();
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 64'h108 || mem_wdata !== 64'h55) begin
            errors++; $display("FAIL store_req: req %b we %b addr %h wdata %h expected 1 1 108 55",
                mem_req, mem_we, mem_addr, mem_wdata);
        end
        mem_ack = 1; mem_rdata = 64'hBAD;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL store_ack_stall: got %b expected 0", stall); end
        step();
        clear_inputs();
        checks++;
        if (mem_req !== 1'b0 || RegWrite_wb !== 1'b0 || ReadData_wb !== 64'hDEADBEEF) begin
            errors++; $display("FAIL store_wb: req %b regwrite %b rdata %h expected 0 0 deadbeef",
                mem_req, RegWrite_wb, ReadData_wb);
        end
        step();
    endtask

    task automatic test_branch();
        Branch = 1; Zero = 1; PCSum = 64'h40;
        #1;
        checks++;
        if (PCSrc !== 1'b1 || BranchTarget !== 64'h40) begin
            errors++; $display("FAIL branch_taken: pcsrc %b target %h expected 1 40", PCSrc, BranchTarget);
        end
        Zero = 0;
        #1;
        checks++;
        if (PCSrc !== 1'b0) begin errors++; $display("FAIL branch_not_taken: got %b expected 0", PCSrc); end
        clear_inputs();
        step();
    endtask

    task automatic test_misalign();
        ALUResult = 64'h103; MemRead = 1; MemtoReg = 1; RegWrite = 1; Rd = 5'd9;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL misalign_stall: got %b expected 0", stall); end
        step();
        clear_inputs();
        checks++;
        if (misalign_err !== 1'b1 || mem_req !== 1'b0 || RegWrite_wb !== 1'b0 || Rd_wb !== 5'd0) begin
            errors++; $display("FAIL misalign_pulse: err %b req %b regwrite %b rd %0d expected 1 0 0 0",
                misalign_err, mem_req, RegWrite_wb, Rd_wb);
        end
        step();
        checks++;
        if (misalign_err !== 1'b0) begin errors++; $display("FAIL misalign_once: got %b expected 0", misalign_err); end
    endtask

    task automatic test_timeout();
        ALUResult = 64'h200; MemRead = 1; MemtoReg = 1; RegWrite = 1; Rd = 5'd2;
        step();
        for (int i = 0; i < int'(TIMEOUT); i++) begin
            checks++;
            if (stall !== ((i < int'(TIMEOUT) - 1) ? 1'b1 : 1'b0) || timeout_err !== 1'b0) begin
                errors++; $display("FAIL timeout_wait[%0d]: stall %b err %b expected %b 0",
                    i, stall, timeout_err, (i < int'(TIMEOUT) - 1));
            end
            if (i == int'(TIMEOUT) - 1) clear_inputs();
            step();
        end
        checks++;
        if (timeout_err !== 1'b1 || mem_req !== 1'b0 || stall !== 1'b0 || RegWrite_wb !== 1'b0) begin
            errors++; $display("FAIL timeout_abort: err %b req %b stall %b regwrite %b expected 1 0 0 0",
                timeout_err, mem_req, stall, RegWrite_wb);
        end
        step();
        checks++;
        if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_once: got %b expected 0", timeout_err); end
    endtask

    task automatic test_reset_mid_access();
        ALUResult = 64'h300; MemRead = 1; MemtoReg = 1; RegWrite = 1; Rd = 5'd4;
        step();
        checks++;
        if (mem_req !== 1'b1) begin errors++; $display("FAIL rstmid_req: got %b expected 1", mem_req); end
        reset = 1'b0;
        clear_inputs();
        step();
        checks++;
        if (mem_req !== 1'b0 || mem_addr !== '0 || ReadData_wb !== '0 || RegWrite_wb !== 1'b0 || stall !== 1'b0) begin
            errors++; $display("FAIL rstmid_clear: req %b addr %h rdata %h regwrite %b stall %b expected all 0",
                mem_req, mem_addr, ReadData_wb, RegWrite_wb, stall);
        end
        reset = 1'b1;
        mem_ack = 1; mem_rdata = 64'h1234;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL late_ack_stall: got %b expected 0", stall); end
        step();
        checks++;
        if (ReadData_wb !== '0 || RegWrite_wb !== 1'b0 || MemtoReg_wb !== 1'b0 || mem_req !== 1'b0) begin
            errors++; $display("FAIL late_ack_ignored: rdata %h regwrite %b memtoreg %b req %b expected 0 0 0 0",
                ReadData_wb, RegWrite_wb, MemtoReg_wb, mem_req);
        end
        clear_inputs();
        step();
    endtask

    initial begin
        test_reset();
        test_alu_op();
        test_load();
        test_store();
        test_branch();
        test_misalign();
        test_timeout();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
